gray_seq_ctrl: RTL and testbench

Command-driven sequencer that owns an up/down Gray-code counter and steps it a requested number of times. It accepts one command at a time over a valid/ready handshake and supports pause, direction and clear. It reports busy, a one-cycle done pulse and a wrap pulse. It sits between a control master and logic that samples gray_out, where only one bit may change per step.

---
 rtl/gray_seq_pkg.sv | 23 ++
 rtl/gray_updown_counter.sv | 65 ++++++
 rtl/gray_seq_ctrl.sv | 96 +++++++++
 tb/tb_gray_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code step sequencer.
// Imported by the counter datapath and the controller.
package gray_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int GRAY_MAXW = 32;

  // Callers zero-extend into and truncate out of the widest supported width.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(
    input logic [GRAY_MAXW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_updown_counter.sv
// Up/down binary counter with a registered Gray-code mirror.
// Clear has priority over stepping and never raises wrap.
module gray_updown_counter
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_q;
  logic             wrap_d;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (clr) begin
      bin_d = ZERO;
    end else if (en) begin
      if (dir == DIR_UP) begin
        bin_d  = bin_q + ONE;
        wrap_d = (bin_q == ONES);
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = (bin_q == ZERO);
      end
    end
  end

  always_comb begin
    gray_d = WIDTH'(bin2gray(GRAY_MAXW'(bin_d)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q  <= ZERO;
      gray_q <= ZERO;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command sequencer: accepts one step command at a time and
// drives the Gray counter until the requested steps are done.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             cmd_clear,
  input  logic             pause,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic             dir_q;
  logic             done_q;

  logic accept;
  logic step;
  logic clr;

  assign accept = (state_q == ST_IDLE) && cmd_valid;
  assign step   = (state_q == ST_RUN) && !pause;
  assign clr    = accept && cmd_clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= ZERO;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            dir_q <= cmd_dir;
            rem_q <= cmd_steps;
            if (cmd_steps != ZERO) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!pause) begin
            rem_q <= rem_q - ONE;
            if (rem_q == ONE) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  gray_updown_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (step),
    .dir (dir_q),
    .clr (clr),
    .bin (bin_out),
    .gray(gray_out),
    .wrap(wrap)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Randomized bench for gray_seq_ctrl with a schedule-based model.
// Each command is expanded into its expected per-cycle outputs.
module tb_gray_seq_ctrl;

  typedef struct {
    logic [3:0] bin;
    bit         busy;
    bit         done;
    bit         wrap;
    bit         ready;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_steps;
  logic       cmd_dir;
  logic       cmd_clear;
  logic       pause;
  logic [3:0] gray_out;
  logic [3:0] bin_out;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks;
  int errors;
  int model_cnt;
  int plan_cnt;
  int plan_np;
  bit [63:0] plan_pm;
  exp_t plan_q[$];
  exp_t exp_q[$];

  logic [3:0] prev_gray;
  bit         prev_busy;

  gray_seq_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps),
    .cmd_dir  (cmd_dir),
    .cmd_clear(cmd_clear),
    .pause    (pause),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Expected outputs for every cycle after acceptance, one entry per edge.
  task automatic plan(input int steps, input bit dir, input bit clr,
                      input bit [63:0] pm);
    int cnt;
    int taken;
    int i;
    bit p;
    bit w;
    plan_q.delete();
    cnt = clr ? 0 : model_cnt;
    plan_q.push_back('{4'(cnt), 1'b1, steps == 0, 1'b0, 1'b0});
    taken = 0;
    i = 0;
    while (taken < steps) begin
      p = (i < 64) ? pm[i] : 1'b0;
      i++;
      w = 1'b0;
      if (!p) begin
        if (dir) begin
          w = (cnt == 15);
          cnt = (cnt + 1) % 16;
        end else begin
          w = (cnt == 0);
          cnt = (cnt + 15) % 16;
        end
        taken++;
      end
      plan_q.push_back('{4'(cnt), 1'b1, taken == steps, w, 1'b0});
    end
    plan_q.push_back('{4'(cnt), 1'b0, 1'b0, 1'b0, 1'b1});
    plan_cnt = cnt;
    plan_np = i;
    plan_pm = pm;
  endtask

  task automatic drive(input int steps, input bit dir, input bit clr);
    bit emptied;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_steps = 4'(steps);
    cmd_dir   = dir;
    cmd_clear = clr;
    pause     = 1'($urandom);
    @(posedge clk);
    #1;
    foreach (plan_q[k]) exp_q.push_back(plan_q[k]);
    model_cnt = plan_cnt;
    for (int i = 0; i < plan_np; i++) begin
      cmd_valid = 1'($urandom);
      cmd_steps = 4'($urandom);
      cmd_dir   = 1'($urandom);
      cmd_clear = 1'($urandom);
      pause     = (i < 64) ? plan_pm[i] : 1'b0;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    pause     = 1'($urandom);
    emptied = 1'b0;
    for (int t = 0; t < 10 && !emptied; t++) begin
      @(negedge clk);
      #1;
      emptied = (exp_q.size() == 0);
    end
    if (!emptied) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{4'(model_cnt), 1'b0, 1'b0, 1'b0, 1'b1};
    check("bin_out", 32'(bin_out), 32'(e.bin));
    check("gray_out", 32'(gray_out), 32'(g(e.bin)));
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
    check("wrap", 32'(wrap), 32'(e.wrap));
    check("cmd_ready", 32'(cmd_ready), 32'(e.ready));
    if (prev_busy && busy && gray_out !== prev_gray)
      check("onebit", 32'($countones(gray_out ^ prev_gray)), 32'd1);
    prev_gray = gray_out;
    prev_busy = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nw;
    checks = 0;
    errors = 0;
    model_cnt = 0;
    prev_busy = 1'b0;
    prev_gray = 4'd0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_steps = 4'd0;
    cmd_dir = 1'b1;
    cmd_clear = 1'b0;
    pause = 1'b0;

    #2 rst = 1'b0;
    #1;
    check("rst_gray", 32'(gray_out), 32'd0);
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    #9 rst = 1'b1;

    plan(5, 1'b1, 1'b1, 64'd0);
    check("up5_g1", 32'(g(plan_q[1].bin)), 32'h1);
    check("up5_g2", 32'(g(plan_q[2].bin)), 32'h3);
    check("up5_g3", 32'(g(plan_q[3].bin)), 32'h2);
    check("up5_g4", 32'(g(plan_q[4].bin)), 32'h6);
    check("up5_g5", 32'(g(plan_q[5].bin)), 32'h7);
    check("up5_done4", 32'(plan_q[4].done), 32'd0);
    check("up5_done5", 32'(plan_q[5].done), 32'd1);
    drive(5, 1'b1, 1'b1);

    plan(3, 1'b0, 1'b1, 64'd0);
    check("dn3_b1", 32'(plan_q[1].bin), 32'hF);
    check("dn3_b3", 32'(plan_q[3].bin), 32'hD);
    check("dn3_g2", 32'(g(plan_q[2].bin)), 32'h9);
    check("dn3_w1", 32'(plan_q[1].wrap), 32'd1);
    check("dn3_w2", 32'(plan_q[2].wrap), 32'd0);
    drive(3, 1'b0, 1'b1);

    plan(4, 1'b1, 1'b1, 64'h1C);
    check("pz_len", 32'(plan_q.size()), 32'd9);
    check("pz_hold", 32'(plan_q[4].bin), 32'h2);
    check("pz_done", 32'(plan_q[7].done), 32'd1);
    check("pz_gray", 32'(g(plan_q[7].bin)), 32'h6);
    drive(4, 1'b1, 1'b1);

    plan(0, 1'b1, 1'b0, 64'd0);
    check("z_len", 32'(plan_q.size()), 32'd2);
    check("z_done", 32'(plan_q[0].done), 32'd1);
    check("z_bin", 32'(plan_q[0].bin), 32'h4);
    drive(0, 1'b1, 1'b0);

    plan(15, 1'b1, 1'b1, 64'd0);
    check("w15_end", 32'(plan_cnt), 32'd15);
    nw = 0;
    foreach (plan_q[k]) nw += int'(plan_q[k].wrap);
    drive(15, 1'b1, 1'b1);
    plan(1, 1'b1, 1'b0, 64'd0);
    foreach (plan_q[k]) nw += int'(plan_q[k].wrap);
    check("w1_end", 32'(plan_cnt), 32'd0);
    check("w_count", 32'(nw), 32'd1);
    drive(1, 1'b1, 1'b0);

    plan(8, 1'b1, 1'b0, 64'd0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_steps = 4'd8;
    cmd_dir = 1'b1;
    cmd_clear = 1'b0;
    pause = 1'b0;
    @(posedge clk);
    #1;
    foreach (plan_q[k]) exp_q.push_back(plan_q[k]);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mr_bin3", 32'(bin_out), 32'h3);
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    #1;
    check("mr_gray", 32'(gray_out), 32'd0);
    check("mr_bin", 32'(bin_out), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_ready", 32'(cmd_ready), 32'd1);
    check("mr_done", 32'(done), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;

    for (int n = 0; n < 40; n++) begin
      int st;
      bit d;
      bit c;
      st = int'($urandom_range(0, 15));
      d = 1'($urandom);
      c = ($urandom_range(0, 3) == 0);
      plan(st, d, c, {$urandom & $urandom, $urandom & $urandom});
      drive(st, d, c);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
